uart_mm_master: RTL and testbench

UART_MM_MASTER -- requirements
Module: uart_mm_master

---
 rtl/uart_mm_master.sv | 150 +++++++++++++++
 tb/tb_uart_mm_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mm_master.sv
// Register-access master that frames host read/write requests as UART byte
// sequences (cmd, addr[, data]) and waits for a single response byte.
module uart_mm_master #(
    parameter int         TimeoutCycles = 1562500,
    parameter logic [7:0] WriteCmd      = 8'h57,
    parameter logic [7:0] ReadCmd       = 8'h52,
    parameter logic [7:0] AckByte       = 8'h06
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_write,
    input  logic [7:0] i_req_addr,
    input  logic [7:0] i_req_wdata,
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output logic [7:0] o_rsp_rdata,
    output logic       o_rsp_error,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic [7:0] o_tx_data,
    input  logic       i_rx_valid,
    output logic       o_rx_ready,
    input  logic [7:0] i_rx_data
);

    localparam int              CntW    = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        SEND_ADDR,
        SEND_DATA,
        WAIT_RSP,
        RESP
    } state_t;

    state_t          state_reg;
    logic            write_reg;
    logic [7:0]      addr_reg;
    logic [7:0]      wdata_reg;
    logic [CntW-1:0] cnt_reg;
    logic            req_ready_reg;
    logic            rsp_valid_reg;
    logic [7:0]      rsp_rdata_reg;
    logic            rsp_error_reg;
    logic            tx_valid_reg;
    logic [7:0]      tx_data_reg;
    logic            rx_ready_reg;

    // Outputs are registered alongside the state so each one already reflects
    // the state the machine is in during the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            write_reg     <= 1'b0;
            addr_reg      <= 8'h00;
            wdata_reg     <= 8'h00;
            cnt_reg       <= '0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 8'h00;
            rsp_error_reg <= 1'b0;
            tx_valid_reg  <= 1'b0;
            tx_data_reg   <= 8'h00;
            rx_ready_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    req_ready_reg <= 1'b1;
                    rx_ready_reg  <= 1'b1;
                    if (i_req_valid && req_ready_reg) begin
                        write_reg     <= i_req_write;
                        addr_reg      <= i_req_addr;
                        wdata_reg     <= i_req_wdata;
                        req_ready_reg <= 1'b0;
                        tx_valid_reg  <= 1'b1;
                        tx_data_reg   <= i_req_write ? WriteCmd : ReadCmd;
                        state_reg     <= SEND_CMD;
                    end
                end
                SEND_CMD: begin
                    if (i_tx_ready) begin
                        tx_data_reg <= addr_reg;
                        state_reg   <= SEND_ADDR;
                    end
                end
                SEND_ADDR: begin
                    if (i_tx_ready) begin
                        if (write_reg) begin
                            tx_data_reg <= wdata_reg;
                            state_reg   <= SEND_DATA;
                        end else begin
                            tx_valid_reg <= 1'b0;
                            cnt_reg      <= '0;
                            state_reg    <= WAIT_RSP;
                        end
                    end
                end
                SEND_DATA: begin
                    if (i_tx_ready) begin
                        tx_valid_reg <= 1'b0;
                        cnt_reg      <= '0;
                        state_reg    <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    // A byte arriving in the final timeout cycle still counts as a reply.
                    if (i_rx_valid && rx_ready_reg) begin
                        rsp_valid_reg <= 1'b1;
                        rx_ready_reg  <= 1'b0;
                        rsp_rdata_reg <= write_reg ? 8'h00 : i_rx_data;
                        rsp_error_reg <= write_reg && (i_rx_data != AckByte);
                        state_reg     <= RESP;
                    end else if (cnt_reg == CntLast) begin
                        rsp_valid_reg <= 1'b1;
                        rx_ready_reg  <= 1'b0;
                        rsp_rdata_reg <= 8'h00;
                        rsp_error_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        rx_ready_reg  <= 1'b1;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = req_ready_reg;
    assign o_rsp_valid = rsp_valid_reg;
    assign o_rsp_rdata = rsp_rdata_reg;
    assign o_rsp_error = rsp_error_reg;
    assign o_tx_valid  = tx_valid_reg;
    assign o_tx_data   = tx_data_reg;
    assign o_rx_ready  = rx_ready_reg;

endmodule

// File: tb/tb_uart_mm_master.sv
// Bench for uart_mm_master: directed and randomized register transactions
// compared against a transaction-level model of the byte framing and response rules.
module tb_uart_mm_master;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_write;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid, rsp_ready, rsp_error;
    logic [7:0] rsp_rdata;
    logic       tx_valid, tx_ready;
    logic [7:0] tx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    uart_mm_master #(.TimeoutCycles(T)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_error(rsp_error),
        .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_tx_data(tx_data),
        .i_rx_valid(rx_valid), .o_rx_ready(rx_ready), .i_rx_data(rx_data)
    );

    int         total = 0;
    int         passed = 0;
    logic [7:0] got_tx[$];
    logic [7:0] last_tx[$];
    logic [7:0] last_rd;
    logic       last_err;
    int         last_k;
    bit         m_idle = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Advance one clock, logging any tx byte handshaken at that edge.
    task automatic step();
        if (tx_valid && tx_ready) got_tx.push_back(tx_data);
        @(posedge clk);
        #1;
    endtask

    // Per-cycle protocol checks against the model's idle flag.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       rst_d = 1'b1;
    always @(negedge clk) begin
        if (rst || rst_d) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("tx_hold_valid", 32'(tx_valid), 32'd1);
                chk("tx_hold_data", 32'(tx_data), 32'(prev_data));
            end
            chk("rx_ready_rule", 32'(rx_ready), 32'(!rsp_valid));
            chk("req_ready_model", 32'(req_ready), 32'(m_idle));
            if (m_idle) chk("idle_quiet", 32'({tx_valid, rsp_valid}), 32'd0);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
        rst_d = rst;
    end

    task automatic run_txn(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                           input int rx_k, input logic [7:0] rx_byte,
                           input bit stray, input bit rnd);
        logic [7:0] exp_q[$];
        logic [7:0] exp_rd;
        logic       exp_err;
        int         n, eff, resp_k;
        bit         stray_done;
        exp_q.push_back(wr ? 8'h57 : 8'h52);
        exp_q.push_back(addr);
        if (wr) exp_q.push_back(wdata);
        if (rx_k >= 1 && rx_k <= T) begin
            eff     = rx_k;
            exp_rd  = wr ? 8'h00 : rx_byte;
            exp_err = wr ? (rx_byte != 8'h06) : 1'b0;
        end else begin
            eff     = T;
            exp_rd  = 8'h00;
            exp_err = 1'b1;
        end

        n = 0;
        while (!req_ready && n < 50) begin step(); n++; end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        if (!req_ready) return;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        got_tx = {};
        step();
        m_idle    = 1'b0;
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = 8'($urandom);
        req_wdata = 8'($urandom);
        chk("tx_latency", 32'({tx_valid, tx_data}), 32'({1'b1, exp_q[0]}));

        stray_done = !stray;
        n = 0;
        while (got_tx.size() < exp_q.size() && n < 300) begin
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!stray_done && got_tx.size() == 1) begin
                rx_valid   = 1'b1;
                rx_data    = 8'hFF;
                tx_ready   = 1'b0;
                stray_done = 1'b1;
            end
            step();
            rx_valid = 1'b0;
            n++;
        end
        chk("tx_count", 32'(got_tx.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_tx.size(); i++)
            chk("tx_byte", 32'(got_tx[i]), 32'(exp_q[i]));
        chk("tx_idle_in_wait", 32'(tx_valid), 32'd0);

        resp_k = -1;
        for (int kk = 1; kk <= T + 8; kk++) begin
            tx_ready = 1'($urandom_range(0, 1));
            rx_valid = (kk == rx_k);
            rx_data  = (kk == rx_k) ? rx_byte : 8'($urandom);
            step();
            rx_valid = 1'b0;
            if (rsp_valid) begin resp_k = kk; break; end
        end
        chk("rsp_cycle", 32'(resp_k), 32'(eff));
        last_tx  = got_tx;
        last_rd  = rsp_rdata;
        last_err = rsp_error;
        last_k   = resp_k;
        if (resp_k < 0) return;
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        chk("rsp_error", 32'(rsp_error), 32'(exp_err));

        repeat ($urandom_range(0, 3)) begin
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom);
            step();
        end
        rx_valid = 1'b0;
        chk("rsp_hold", 32'({rsp_valid, rsp_error, rsp_rdata}), 32'({1'b1, exp_err, exp_rd}));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        m_idle    = 1'b1;
        chk("rsp_done", 32'({rsp_valid, req_ready}), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        rsp_ready = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        step(); step();
        chk("reset_vals", 32'({req_ready, rsp_valid, rsp_rdata, rsp_error, tx_valid, tx_data, rx_ready}), 32'd0);
        rst = 1'b0;
        step();
        m_idle = 1'b1;
        chk("reset_release_ready", 32'({req_ready, rx_ready}), 32'd3);

        // Write with ack, tx always ready.
        run_txn(1'b1, 8'h00, 8'hA5, 3, 8'h06, 1'b0, 1'b0);
        chk("lit_w_bytes", 32'({last_tx[0], last_tx[1], last_tx[2]}), 32'h5700A5);
        chk("lit_w_rsp", 32'({last_err, last_rd}), 32'h000);
        // Read returning 3C.
        run_txn(1'b0, 8'h01, 8'h00, 2, 8'h3C, 1'b0, 1'b0);
        chk("lit_r_bytes", 32'({last_tx[0], last_tx[1]}), 32'h5201);
        chk("lit_r_rsp", 32'({last_err, last_rd}), 32'h03C);
        // Write with NAK.
        run_txn(1'b1, 8'h10, 8'h77, 1, 8'h15, 1'b0, 1'b0);
        chk("lit_nak_err", 32'(last_err), 32'd1);
        // Read timeout.
        run_txn(1'b0, 8'h22, 8'h00, 0, 8'h00, 1'b0, 1'b0);
        chk("lit_timeout", 32'({last_err, last_rd}), 32'h100);
        chk("lit_timeout_cycle", 32'(last_k), 32'd16);
        // Reply byte on the final timeout cycle wins.
        run_txn(1'b0, 8'h33, 8'h00, T, 8'h5A, 1'b0, 1'b0);
        chk("lit_rx_wins", 32'({last_err, last_rd}), 32'h05A);
        // Stalling transmitter plus stray byte during the address phase.
        run_txn(1'b1, 8'h44, 8'h99, 5, 8'h06, 1'b1, 1'b1);

        // Reset while the data byte is on the wire.
        n = 0;
        while (!req_ready && n < 50) begin step(); n++; end
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h55; req_wdata = 8'hC3;
        got_tx = {};
        step();
        m_idle = 1'b0;
        req_valid = 1'b0;
        tx_ready = 1'b1;
        n = 0;
        while (got_tx.size() < 2 && n < 20) begin step(); n++; end
        chk("mid_send_data", 32'({tx_valid, tx_data}), 32'h1C3);
        tx_ready = 1'b0;
        rst = 1'b1;
        step();
        chk("mid_reset_outs", 32'({tx_valid, req_ready, rx_ready, rsp_valid}), 32'd0);
        rst = 1'b0;
        step();
        m_idle = 1'b1;
        chk("mid_reset_release", 32'({req_ready, tx_valid}), 32'h2);

        for (int t = 0; t < 30; t++) begin
            bit         wr;
            int         k;
            logic [7:0] b;
            wr = 1'($urandom_range(0, 1));
            k  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, T);
            b  = (wr && $urandom_range(0, 1) == 1) ? 8'h06 : 8'($urandom);
            run_txn(wr, 8'($urandom), 8'($urandom), k, b, 1'($urandom_range(0, 1)), 1'b1);
        end

        step(); step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
